// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI mode-0 target with RX FIFO and TX holding register; optional SPI_SLAVE_RESPONDER_STATS_EN counters
module spi_slave_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int RX_DEPTH = 16,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        spi_external_SCLK,
  input  logic        spi_external_SS_n,
  input  logic        spi_external_MOSI,
  output logic        spi_external_MISO,
  output logic        spi_external_MISO_oe,
  output logic [8:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        frame_active,
  output logic        frame_end,
  output logic        rx_overrun,
`ifdef SPI_SLAVE_RESPONDER_STATS_EN
  input  logic        stats_clr,
  output logic [23:0] stats,
`endif
  output logic        tx_underrun
);
  localparam int AW = $clog2(RX_DEPTH);
  typedef enum logic [1:0] {DESEL_WAIT, IDLE, ACTIVE} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_d, ss_d, first_flag, byte_done, hold_full;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, hold_data;
  logic [8:0] mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] rx_cnt;
  logic sclk_s, ss_s, mosi_s, in_act, start, end_f, bit_rise, bit_fall, ld, push, full, push_ok, pop, wr;
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign in_act = state == ACTIVE;
  assign start = state == IDLE && !ss_s && ss_d;
  assign end_f = in_act && ss_s && !ss_d;
  // a select edge pre-empts any clock edge seen in the same cycle
  assign bit_rise = in_act && !end_f && sclk_s && !sclk_d;
  assign bit_fall = in_act && !end_f && !sclk_s && sclk_d;
  assign ld = start || (bit_fall && bit_cnt == 3'd0 && byte_done);
  assign push = bit_rise && bit_cnt == 3'd7;
  assign full = rx_cnt == (AW+1)'(RX_DEPTH);
  assign push_ok = push && !full;
  assign rx_valid = rx_cnt != '0;
  assign pop = rx_valid && rx_ready;
  assign wr = tx_valid && tx_ready;
  assign tx_ready = !hold_full;
  assign rx_data = rx_valid ? mem[rd_ptr] : '0;
  assign frame_active = in_act;
  assign spi_external_MISO_oe = in_act;
  assign spi_external_MISO = in_act ? tx_shift[7] : 1'b1;
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync <= '0;
      ss_sync <= '0;
      mosi_sync <= '0;
      sclk_d <= 1'b0;
      ss_d <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_external_SCLK};
      ss_sync <= {ss_sync[SYNC_STAGES-2:0], spi_external_SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_external_MOSI};
      sclk_d <= sclk_s;
      ss_d <= ss_s;
    end
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= DESEL_WAIT;
      bit_cnt <= '0;
      first_flag <= 1'b0;
      byte_done <= 1'b0;
      rx_shift <= '0;
      tx_shift <= IDLE_BYTE;
      hold_data <= '0;
      hold_full <= 1'b0;
      frame_end <= 1'b0;
      rx_overrun <= 1'b0;
      tx_underrun <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_cnt <= '0;
    end else begin
      frame_end <= end_f;
      rx_overrun <= push && full;
      tx_underrun <= ld && !hold_full;
      if (state == DESEL_WAIT && ss_s) state <= IDLE;
      if (start) begin
        state <= ACTIVE;
        bit_cnt <= '0;
        first_flag <= 1'b1;
        byte_done <= 1'b0;
      end
      if (end_f) state <= IDLE;
      if (bit_rise) begin
        rx_shift <= {rx_shift[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (push) begin
        first_flag <= 1'b0;
        byte_done <= 1'b1;
      end
      if (ld) tx_shift <= hold_full ? hold_data : IDLE_BYTE;
      else if (bit_fall) tx_shift <= {tx_shift[6:0], 1'b0};
      if (wr) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (ld) hold_full <= 1'b0;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      rx_cnt <= rx_cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk_clk) begin
    if (push_ok) mem[wr_ptr] <= {first_flag, rx_shift[6:0], mosi_s};
  end
`ifdef SPI_SLAVE_RESPONDER_STATS_EN
  logic [7:0] ovr_cnt, und_cnt, frm_cnt;
  assign stats = {frm_cnt, und_cnt, ovr_cnt};
  always_ff @(posedge clk_clk) begin
    if (reset_reset || stats_clr) begin
      ovr_cnt <= '0;
      und_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      if (rx_overrun && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      if (tx_underrun && und_cnt != 8'hFF) und_cnt <= und_cnt + 8'd1;
      if (frame_end) frm_cnt <= frm_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: directed SPI host sequences against spi_slave_responder
module tb_spi_slave_responder;
  logic clk = 0, rst = 1, sclk = 0, ss_n = 1, mosi = 0, rx_ready = 0, tx_valid = 0;
  logic [7:0] tx_data = '0;
  logic miso, miso_oe, rx_valid, tx_ready, frame_active, frame_end, rx_overrun, tx_underrun;
  logic [8:0] rx_data;
`ifdef SPI_SLAVE_RESPONDER_STATS_EN
  logic stats_clr = 0;
  logic [23:0] stats;
`endif
  int n_vec = 0, n_err = 0, fe_n = 0, ov_n = 0, un_n = 0;
  logic [8:0] rxq[$];
  spi_slave_responder dut (
    .clk_clk(clk), .reset_reset(rst),
    .spi_external_SCLK(sclk), .spi_external_SS_n(ss_n), .spi_external_MOSI(mosi),
    .spi_external_MISO(miso), .spi_external_MISO_oe(miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_active(frame_active), .frame_end(frame_end), .rx_overrun(rx_overrun),
`ifdef SPI_SLAVE_RESPONDER_STATS_EN
    .stats_clr(stats_clr), .stats(stats),
`endif
    .tx_underrun(tx_underrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_end) fe_n++;
    if (rx_overrun) ov_n++;
    if (tx_underrun) un_n++;
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hw(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ss_low();
    ss_n = 0;
    hw(10);
  endtask
  task automatic ss_high();
    hw(5);
    ss_n = 1;
    hw(10);
  endtask
  task automatic xbits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      mosi = mo[7-i];
      hw(5);
      mi[7-i] = miso;
      sclk = 1;
      hw(5);
      sclk = 0;
    end
  endtask
  initial begin
    logic [7:0] mi;
    logic [7:0] pat [18];
    int b0, f0, u0, o0;
    hw(3);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_miso", miso, 1);
    chk("rst_oe", miso_oe, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_active", frame_active, 0);
    rst = 0;
    hw(6);
    rx_ready = 1;
    b0 = rxq.size(); f0 = fe_n;
    ss_low();
    chk("t1_active", frame_active, 1);
    chk("t1_oe", miso_oe, 1);
    xbits(8'hA5, 8, mi);
    chk("t1_miso_idle", mi, 8'hFF);
    xbits(8'h3C, 8, mi);
    ss_high();
    chk("t1_count", rxq.size() - b0, 2);
    chk("t1_byte0", rxq[b0], 9'h1A5);
    chk("t1_byte1", rxq[b0+1], 9'h03C);
    chk("t1_frame_end", fe_n - f0, 1);
    chk("t1_inactive", frame_active, 0);
    tx_data = 8'h81; tx_valid = 1;
    hw(1);
    tx_valid = 0;
    chk("t2_tx_full", tx_ready, 0);
    u0 = un_n;
    ss_low();
    chk("t2_tx_ready_back", tx_ready, 1);
    chk("t2_no_underrun", un_n - u0, 0);
    xbits(8'h00, 8, mi);
    chk("t2_miso_b0", mi, 8'h81);
    hw(5);
    chk("t2_one_underrun", un_n - u0, 1);
    xbits(8'h00, 8, mi);
    chk("t2_miso_b1", mi, 8'hFF);
    ss_high();
    rx_ready = 0;
    hw(2);
    for (int i = 0; i < 18; i++) pat[i] = 8'(i * 37 + 5);
    b0 = rxq.size(); o0 = ov_n;
    ss_low();
    for (int i = 0; i < 18; i++) xbits(pat[i], 8, mi);
    ss_high();
    chk("t3_overruns", ov_n - o0, 2);
    chk("t3_head", rx_data, {1'b1, pat[0]});
    rx_ready = 1;
    hw(25);
    chk("t3_count", rxq.size() - b0, 16);
    for (int k = 0; k < 16; k++) chk("t3_entry", rxq[b0+k], {k == 0, pat[k]});
    chk("t3_empty", rx_valid, 0);
    b0 = rxq.size(); f0 = fe_n;
    ss_low();
    xbits(8'h5A, 8, mi);
    xbits(8'hC3, 5, mi);
    ss_high();
    chk("t4_count", rxq.size() - b0, 1);
    chk("t4_byte", rxq[b0], 9'h15A);
    chk("t4_frame_end", fe_n - f0, 1);
    ss_low();
    xbits(8'h77, 8, mi);
    ss_high();
    chk("t4_next_first", rxq[b0+1], 9'h177);
    ss_low();
    xbits(8'hF0, 3, mi);
    rst = 1;
    hw(3);
    rst = 0;
    b0 = rxq.size();
    xbits(8'h12, 8, mi);
    chk("t5_oe", miso_oe, 0);
    chk("t5_miso", miso, 1);
    xbits(8'h34, 8, mi);
    chk("t5_inactive", frame_active, 0);
    chk("t5_no_push", rxq.size() - b0, 0);
    ss_high();
    ss_low();
    chk("t5_active", frame_active, 1);
    xbits(8'h9C, 8, mi);
    ss_high();
    chk("t5_count", rxq.size() - b0, 1);
    chk("t5_byte", rxq[b0], 9'h19C);
`ifdef SPI_SLAVE_RESPONDER_STATS_EN
    tx_data = 8'h55; tx_valid = 1;
    stats_clr = 1;
    hw(1);
    stats_clr = 0;
    rx_ready = 0;
    hw(3);
    for (int f = 0; f < 2; f++) begin
      ss_low();
      for (int i = 0; i < 9; i++) xbits(pat[i], 8, mi);
      ss_high();
    end
    ss_low();
    ss_high();
    chk("st_counts", stats, 24'h030002);
    stats_clr = 1;
    hw(1);
    stats_clr = 0;
    chk("st_cleared", stats, 24'h000000);
    tx_valid = 0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
